// File: rtl/telemetry_scheduler.sv
// Round-robin collector of per-signal telemetry samples into a shadow buffer, committed to the
// display registers once per frame. Optional staleness tracking is enabled by TELEMETRY_STALE_EN.
module telemetry_scheduler #(
  parameter int NUM_SIGNALS  = 7,
  parameter int VALUE_WIDTH  = 9,
  parameter int STALE_FRAMES = 60
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    frame_start,
  input  logic                                    freeze,
  input  logic [NUM_SIGNALS-1:0]                  req_valid,
  input  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] req_value,
  output logic [NUM_SIGNALS-1:0]                  req_ready,
  output logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] telemetry_values,
  output logic [NUM_SIGNALS-1:0]                  dirty,
  output logic                                    commit_pulse,
  output logic [NUM_SIGNALS-1:0]                  stale
);

  localparam int PTR_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;

  typedef enum logic {COLLECT, COMMIT} state_t;

  state_t                                  state;
  logic [PTR_W-1:0]                        rr_ptr;
  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] shadow;

  logic                   grant_any;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [NUM_SIGNALS-1:0] grant;
  int                     cand;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_SIGNALS) cand = cand - NUM_SIGNALS;
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = PTR_W'(cand);
        grant[cand] = 1'b1;
      end
    end
    next_ptr = (int'(grant_idx) == NUM_SIGNALS - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  // Grants are withheld during the commit cycle and while reset is held.
  assign req_ready = (state == COLLECT && reset) ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  // NOTE: the shadow buffer is reset too, so an uncommitted slot never exposes power-up garbage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= COLLECT;
      rr_ptr           <= '0;
      shadow           <= '0;
      telemetry_values <= '0;
      dirty            <= '0;
      commit_pulse     <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        COLLECT: begin
          if (grant_any) begin
            shadow[grant_idx] <= req_value[grant_idx];
            dirty[grant_idx]  <= 1'b1;
            rr_ptr            <= next_ptr;
          end
          if (frame_start && !freeze) begin
            state        <= COMMIT;
            commit_pulse <= 1'b1;
          end
        end
        COMMIT: begin
          for (int s = 0; s < NUM_SIGNALS; s++) begin
            if (dirty[s]) telemetry_values[s] <= shadow[s];
          end
          dirty <= '0;
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef TELEMETRY_STALE_EN
  localparam int CNT_W = $clog2(STALE_FRAMES + 1);
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(STALE_FRAMES);

  logic [NUM_SIGNALS-1:0][CNT_W-1:0] age;

  // Ageing happens only on real commits, so a frozen overlay does not drift towards stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age   <= '0;
      stale <= '0;
    end else if (state == COMMIT) begin
      for (int s = 0; s < NUM_SIGNALS; s++) begin
        if (dirty[s]) begin
          age[s]   <= '0;
          stale[s] <= 1'b0;
        end else begin
          if (age[s] != AGE_MAX) age[s] <= age[s] + CNT_W'(1);
          stale[s] <= (age[s] >= AGE_MAX - CNT_W'(1));
        end
      end
    end
  end
`else
  assign stale = '0;
`endif

endmodule

// File: tb/tb_telemetry_scheduler.sv
// Self-checking bench for telemetry_scheduler: arbitration vector table, commit scoreboard,
// and hand sequences for freeze, frame_start collisions, staleness and reset during commit.
module tb_telemetry_scheduler;

  localparam int N  = 7;
  localparam int VW = 9;
  localparam int SF = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   frame_start;
  logic                   freeze;
  logic [N-1:0]           req_valid;
  logic [N-1:0][VW-1:0]   req_value;
  logic [N-1:0]           req_ready;
  logic [N-1:0][VW-1:0]   telemetry_values;
  logic [N-1:0]           dirty;
  logic                   commit_pulse;
  logic [N-1:0]           stale;

  telemetry_scheduler #(
    .NUM_SIGNALS (N),
    .VALUE_WIDTH (VW),
    .STALE_FRAMES(SF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .freeze          (freeze),
    .req_valid       (req_valid),
    .req_value       (req_value),
    .req_ready       (req_ready),
    .telemetry_values(telemetry_values),
    .dirty           (dirty),
    .commit_pulse    (commit_pulse),
    .stale           (stale)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_commits = 0;

  // Reference model of the scheduler's observable behaviour.
  logic [N-1:0][VW-1:0] m_shadow, m_tv;
  logic [N-1:0]         m_dirty, m_stale;
  int                   m_ptr;
  bit                   m_commit;
  int                   m_cnt[N];
  logic [N-1:0][VW-1:0] exp_q[$];
  bit                   sb_pending;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } arb_vec_t;

  arb_vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    bit found;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int s;
      s = (m_ptr + i) % N;
      if (!found && v[s]) begin
        g[s]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [N-1:0] exp_stale();
`ifdef TELEMETRY_STALE_EN
    return m_stale;
`else
    return '0;
`endif
  endfunction

  task automatic model_clear();
    m_shadow   = '0;
    m_tv       = '0;
    m_dirty    = '0;
    m_stale    = '0;
    m_ptr      = 0;
    m_commit   = 1'b0;
    sb_pending = 1'b0;
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, sample 2 time units before posedge, update model at posedge.
  task automatic step(input logic [N-1:0] v, input logic fs, input logic frz, input string tag,
                      output logic [N-1:0] rdy);
    logic [N-1:0]         g;
    logic [N-1:0][VW-1:0] exp_tv;
    req_valid   = v;
    frame_start = fs;
    freeze      = frz;
    #3;
    if (sb_pending) begin
      sb_pending = 1'b0;
      check({tag, " sb_entry"}, 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        exp_tv = exp_q.pop_front();
        check({tag, " sb_commit_values"}, 64'(telemetry_values), 64'(exp_tv));
      end
    end
    g   = m_commit ? '0 : model_grant(v);
    rdy = req_ready;
    check({tag, " ready"},        64'(req_ready),        64'(g));
    check({tag, " commit_pulse"}, 64'(commit_pulse),     64'(m_commit));
    check({tag, " dirty"},        64'(dirty),            64'(m_dirty));
    check({tag, " values"},       64'(telemetry_values), 64'(m_tv));
    check({tag, " stale"},        64'(stale),            64'(exp_stale()));
    if (commit_pulse) begin
      n_commits++;
      sb_pending = 1'b1;
    end
    @(posedge clk);
    if (m_commit) begin
      for (int s = 0; s < N; s++) begin
        if (m_dirty[s]) begin
          m_tv[s]  = m_shadow[s];
          m_cnt[s] = 0;
        end else if (m_cnt[s] < SF) begin
          m_cnt[s]++;
        end
        m_stale[s] = (m_cnt[s] == SF);
      end
      m_dirty  = '0;
      m_commit = 1'b0;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (g[s]) begin
          m_shadow[s] = req_value[s];
          m_dirty[s]  = 1'b1;
          m_ptr       = (s + 1) % N;
        end
      end
      if (fs && !frz) begin
        m_commit = 1'b1;
        exp_tv   = m_tv;
        for (int s = 0; s < N; s++) if (m_dirty[s]) exp_tv[s] = m_shadow[s];
        exp_q.push_back(exp_tv);
      end
    end
    @(negedge clk);
  endtask

  // Assert reset asynchronously (shortly after a negedge), check cleared outputs, then release.
  task automatic apply_reset(input int cycles, input string tag);
    #1;
    reset     = 1'b0;
    req_valid = '1;
    for (int c = 0; c < cycles; c++) begin
      #2;
      check({tag, " rst_ready"},  64'(req_ready),        64'(0));
      check({tag, " rst_pulse"},  64'(commit_pulse),     64'(0));
      check({tag, " rst_values"}, 64'(telemetry_values), 64'(0));
      check({tag, " rst_dirty"},  64'(dirty),            64'(0));
      check({tag, " rst_stale"},  64'(stale),            64'(0));
      @(negedge clk);
    end
    req_valid = '0;
    reset     = 1'b1;
    model_clear();
  endtask

  logic [N-1:0] rdy;

  initial begin
    vecs[0]  = '{7'h7F, 7'h01};
    vecs[1]  = '{7'h7F, 7'h02};
    vecs[2]  = '{7'h7F, 7'h04};
    vecs[3]  = '{7'h7F, 7'h08};
    vecs[4]  = '{7'h7F, 7'h10};
    vecs[5]  = '{7'h7F, 7'h20};
    vecs[6]  = '{7'h7F, 7'h40};
    vecs[7]  = '{7'h7F, 7'h01};
    vecs[8]  = '{7'h00, 7'h00};
    vecs[9]  = '{7'h01, 7'h01};
    vecs[10] = '{7'h41, 7'h40};
    vecs[11] = '{7'h41, 7'h01};
    vecs[12] = '{7'h0C, 7'h04};
    vecs[13] = '{7'h0C, 7'h08};
    vecs[14] = '{7'h0C, 7'h04};

    reset       = 1'b0;
    frame_start = 1'b0;
    freeze      = 1'b0;
    req_valid   = '0;
    for (int s = 0; s < N; s++) req_value[s] = VW'(9'h100 + s);
    model_clear();
    @(negedge clk);
    apply_reset(3, "init");

    // Round-robin arbitration from a freshly reset pointer.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].valid, 1'b0, 1'b0, $sformatf("arb%0d", i), rdy);
      check($sformatf("arb%0d table_ready", i), 64'(rdy), 64'(vecs[i].exp_ready));
    end
    step('0, 1'b1, 1'b0, "c0_fs", rdy);
    step('0, 1'b0, 1'b0, "c0_commit", rdy);
    step('0, 1'b0, 1'b0, "c0_after", rdy);

    // Single write then commit.
    req_value[2] = 9'h1A5;
    step(7'h04, 1'b0, 1'b0, "w2", rdy);
    step('0, 1'b1, 1'b0, "w2_fs", rdy);
    step('0, 1'b0, 1'b0, "w2_commit", rdy);
    step('0, 1'b0, 1'b0, "w2_after", rdy);
    check("w2 slot_value", 64'(telemetry_values[2]), 64'(9'h1A5));
    check("w2 dirty_clear", 64'(dirty), 64'(0));

    // Last write wins; freeze holds the display through several frames.
    req_value[4] = 9'd5;
    step(7'h10, 1'b0, 1'b0, "w4a", rdy);
    req_value[4] = 9'd300;
    step(7'h10, 1'b0, 1'b0, "w4b", rdy);
    for (int k = 0; k < 3; k++) begin
      step('0, 1'b1, 1'b1, $sformatf("frz_fs%0d", k), rdy);
      step('0, 1'b0, 1'b1, $sformatf("frz_idle%0d", k), rdy);
    end
    check("frz slot_held", 64'(telemetry_values[4]), 64'(9'h104));
    check("frz dirty_kept", 64'(dirty[4]), 64'(1));
    step('0, 1'b0, 1'b0, "unfrz_idle", rdy);
    check("unfrz no_commit", 64'(telemetry_values[4]), 64'(9'h104));
    step('0, 1'b1, 1'b0, "unfrz_fs", rdy);
    step('0, 1'b0, 1'b0, "unfrz_commit", rdy);
    step('0, 1'b0, 1'b0, "unfrz_after", rdy);
    check("unfrz slot_value", 64'(telemetry_values[4]), 64'(9'd300));

    // Grant coincides with frame_start; a second frame_start lands in the commit cycle.
    n_commits = 0;
    req_value[5] = 9'h0AA;
    step(7'h20, 1'b1, 1'b0, "coll_fs", rdy);
    step('0, 1'b1, 1'b0, "coll_fs2", rdy);
    step('0, 1'b0, 1'b0, "coll_after", rdy);
    step('0, 1'b0, 1'b0, "coll_after2", rdy);
    check("coll slot_value", 64'(telemetry_values[5]), 64'(9'h0AA));
    check("coll one_commit", 64'(n_commits), 64'(1));

    // Staleness of a silent slot, then recovery on a fresh write.
    req_value[1] = 9'h055;
    step(7'h02, 1'b1, 1'b0, "st_w", rdy);
    step('0, 1'b0, 1'b0, "st_w_commit", rdy);
    for (int k = 0; k < 3; k++) begin
      step('0, 1'b1, 1'b0, $sformatf("st_fs%0d", k), rdy);
      step('0, 1'b0, 1'b0, $sformatf("st_commit%0d", k), rdy);
    end
    step('0, 1'b0, 1'b0, "st_check", rdy);
`ifdef TELEMETRY_STALE_EN
    check("st stale_set", 64'(stale[1]), 64'(1));
`else
    check("st stale_off", 64'(stale[1]), 64'(0));
`endif
    step(7'h02, 1'b1, 1'b0, "st_refresh", rdy);
    step('0, 1'b0, 1'b0, "st_refresh_commit", rdy);
    step('0, 1'b0, 1'b0, "st_refresh_after", rdy);
    check("st stale_clear", 64'(stale[1]), 64'(0));

    // Reset asserted during the commit cycle discards the pending commit.
    req_value[6] = 9'h1FF;
    step(7'h40, 1'b0, 1'b0, "rc_w", rdy);
    step('0, 1'b1, 1'b0, "rc_fs", rdy);
    apply_reset(2, "rc");
    step(7'h7F, 1'b0, 1'b0, "rc_first_grant", rdy);
    check("rc grant_s0", 64'(rdy), 64'(7'h01));
    step('0, 1'b0, 1'b0, "rc_idle", rdy);

    check("sb drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
